// File: rtl/nor_gate_checker.sv
// Stimulus sequencer and checker for the two-input NOR-derived gate block.
// Optional first-failure capture ports are built when NOR_CHK_FIRST_FAIL_EN is defined.
module nor_gate_checker #(
    parameter int HOLD_CYCLES = 4,
    parameter int SWEEPS      = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic       and_in,
    input  logic       or_in,
    input  logic       not_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_cnt,
`ifdef NOR_CHK_FIRST_FAIL_EN
    output logic [1:0] ff_vec,
    output logic [2:0] ff_bits,
`endif
    output logic [1:0] fsm_state
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [7:0] HOLD_LAST  = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] SWEEP_LAST = 8'(SWEEPS - 1);

    logic [1:0] state;
    logic [7:0] hold_cnt;
    logic [7:0] sweep_cnt;
    logic [1:0] vec_idx;
    logic [2:0] mask;
    logic       sample;
    logic       fail;
    logic       last_sample;
    logic [7:0] err_next;

    // The vector index is the stimulus itself; it rests at 00 outside a run.
    assign {a, b}    = vec_idx;
    assign fsm_state = state;

    always_comb begin
        mask        = {and_in ^ (a & b), or_in ^ (a | b), not_in ^ ~a};
        sample      = (state == RUN) && (hold_cnt == HOLD_LAST);
        fail        = sample && (mask != 3'b000);
        last_sample = sample && (vec_idx == 2'd3) && (sweep_cnt == SWEEP_LAST);
        err_next    = (fail && (err_cnt != 8'hFF)) ? err_cnt + 8'd1 : err_cnt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            hold_cnt  <= 8'd0;
            sweep_cnt <= 8'd0;
            vec_idx   <= 2'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_cnt   <= 8'd0;
`ifdef NOR_CHK_FIRST_FAIL_EN
            ff_vec    <= 2'd0;
            ff_bits   <= 3'd0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        hold_cnt  <= 8'd0;
                        sweep_cnt <= 8'd0;
                        vec_idx   <= 2'd0;
                        err_cnt   <= 8'd0;
                        pass      <= 1'b0;
`ifdef NOR_CHK_FIRST_FAIL_EN
                        ff_vec    <= 2'd0;
                        ff_bits   <= 3'd0;
`endif
                    end
                end
                RUN: begin
                    err_cnt <= err_next;
`ifdef NOR_CHK_FIRST_FAIL_EN
                    // A zero count means no earlier failure in this run (it saturates, never wraps).
                    if (fail && (err_cnt == 8'd0)) begin
                        ff_vec  <= vec_idx;
                        ff_bits <= mask;
                    end
`endif
                    if (sample) begin
                        hold_cnt <= 8'd0;
                        vec_idx  <= vec_idx + 2'd1;
                        if (vec_idx == 2'd3)
                            sweep_cnt <= sweep_cnt + 8'd1;
                        if (last_sample) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_next == 8'd0);
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nor_gate_checker.sv
// Bench for nor_gate_checker: three instances (HOLD/SWEEPS 4/1, 4/2, 1/100) each
// driving a gate model whose outputs are corrupted by a per-vector fault table.
module tb_nor_gate_checker;

    localparam int LIMIT = 2000;

    logic       clk;
    logic       rst_n;
    logic [2:0] start_v;
    logic [2:0] a_v, b_v, and_v, or_v, not_v;
    logic [2:0] busy_v, done_v, pass_v;
    logic [7:0] err_v [3];
    logic [1:0] st_v [3];
    logic [1:0] ff_vec_v [3];
    logic [2:0] ff_bits_v [3];
    logic [2:0] flt [3][4];

    int tests = 0;
    int fails = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gate under test: correct derived outputs XOR a fault mask {and,or,not} per vector.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            and_v[i] = (a_v[i] & b_v[i]) ^ flt[i][{a_v[i], b_v[i]}][2];
            or_v[i]  = (a_v[i] | b_v[i]) ^ flt[i][{a_v[i], b_v[i]}][1];
            not_v[i] = (~a_v[i])         ^ flt[i][{a_v[i], b_v[i]}][0];
        end
    end

`ifdef NOR_CHK_FIRST_FAIL_EN
    `define FF_PORTS(k) .ff_vec(ff_vec_v[k]), .ff_bits(ff_bits_v[k]),
`else
    `define FF_PORTS(k)
    initial begin
        for (int i = 0; i < 3; i++) begin
            ff_vec_v[i]  = 2'd0;
            ff_bits_v[i] = 3'd0;
        end
    end
`endif

    nor_gate_checker #(.HOLD_CYCLES(4), .SWEEPS(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]),
        .and_in(and_v[0]), .or_in(or_v[0]), .not_in(not_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_cnt(err_v[0]),
        `FF_PORTS(0) .fsm_state(st_v[0]));

    nor_gate_checker #(.HOLD_CYCLES(4), .SWEEPS(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]),
        .and_in(and_v[1]), .or_in(or_v[1]), .not_in(not_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_cnt(err_v[1]),
        `FF_PORTS(1) .fsm_state(st_v[1]));

    nor_gate_checker #(.HOLD_CYCLES(1), .SWEEPS(100)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a(a_v[2]), .b(b_v[2]),
        .and_in(and_v[2]), .or_in(or_v[2]), .not_in(not_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .err_cnt(err_v[2]),
        `FF_PORTS(2) .fsm_state(st_v[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_flt(input int k, input logic [2:0] m0, input logic [2:0] m1,
                           input logic [2:0] m2, input logic [2:0] m3);
        flt[k][0] = m0; flt[k][1] = m1; flt[k][2] = m2; flt[k][3] = m3;
    endtask

    // Launch one run on instance k and check it against the fault-table model.
    task automatic run_chk(input string tag, input int k, input int hold, input int sweeps);
        int exp_err, cyc;
        logic [1:0] exp_ffv;
        logic [2:0] exp_ffb;
        exp_err = 0; exp_ffv = 2'd0; exp_ffb = 3'd0;
        for (int s = 0; s < sweeps; s++)
            for (int v = 0; v < 4; v++)
                if (flt[k][v] != 3'd0) begin
                    if (exp_err == 0) begin
                        exp_ffv = 2'(v);
                        exp_ffb = flt[k][v];
                    end
                    if (exp_err < 255) exp_err++;
                end
`ifndef NOR_CHK_FIRST_FAIL_EN
        exp_ffv = 2'd0; exp_ffb = 3'd0;
`endif
        start_v[k] = 1'b1;
        @(negedge clk);
        start_v[k] = 1'b0;
        chk({tag, "_busy_first"}, 32'(busy_v[k]), 32'd1);
        chk({tag, "_ab_first"}, 32'({a_v[k], b_v[k]}), 32'd0);
        cyc = 0;
        while (busy_v[k] && cyc < LIMIT) begin
            cyc++;
            @(negedge clk);
        end
        chk({tag, "_busy_len"}, 32'(cyc), 32'(4 * hold * sweeps));
        chk({tag, "_done"}, 32'(done_v[k]), 32'd1);
        chk({tag, "_err"}, 32'(err_v[k]), 32'(exp_err));
        chk({tag, "_pass"}, 32'(pass_v[k]), 32'(exp_err == 0));
        chk({tag, "_ab_end"}, 32'({a_v[k], b_v[k]}), 32'd0);
        chk({tag, "_ff_vec"}, 32'(ff_vec_v[k]), 32'(exp_ffv));
        chk({tag, "_ff_bits"}, 32'(ff_bits_v[k]), 32'(exp_ffb));
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done_v[k]), 32'd0);
        chk({tag, "_pass_hold"}, 32'(pass_v[k]), 32'(exp_err == 0));
    endtask

    initial begin
        int  cyc;
        logic saw_done;
        rst_n   = 1'b0;
        start_v = 3'b000;
        for (int i = 0; i < 3; i++) set_flt(i, 3'd0, 3'd0, 3'd0, 3'd0);
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy_v[0]), 32'd0);
        chk("rst_done", 32'(done_v[0]), 32'd0);
        chk("rst_pass", 32'(pass_v[0]), 32'd0);
        chk("rst_err", 32'(err_v[0]), 32'd0);
        chk("rst_ab", 32'({a_v[0], b_v[0]}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed scenarios.
        run_chk("good", 0, 4, 1);
        set_flt(0, 3'b000, 3'b010, 3'b010, 3'b010);
        run_chk("or_stuck0", 0, 4, 1);
        set_flt(1, 3'b001, 3'b001, 3'b001, 3'b001);
        run_chk("not_inv", 1, 4, 2);
        set_flt(2, 3'b111, 3'b111, 3'b111, 3'b111);
        run_chk("saturate", 2, 1, 100);

        // Randomized fault tables and idle gaps.
        for (int r = 0; r < 8; r++) begin
            for (int v = 0; v < 4; v++)
                flt[1][v] = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_chk("rand", 1, 4, 2);
        end
        for (int v = 0; v < 4; v++) flt[2][v] = 3'($urandom_range(0, 7));
        run_chk("rand_h1", 2, 1, 100);

        // Reset in the middle of a run.
        set_flt(0, 3'b111, 3'b111, 3'b111, 3'b111);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_err_before", 32'(err_v[0]), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_busy", 32'(busy_v[0]), 32'd0);
        chk("mid_ab", 32'({a_v[0], b_v[0]}), 32'd0);
        chk("mid_err", 32'(err_v[0]), 32'd0);
        saw_done = done_v[0];
        repeat (20) begin
            @(negedge clk);
            saw_done |= done_v[0];
        end
        chk("mid_no_done", 32'(saw_done), 32'd0);
        set_flt(0, 3'd0, 3'd0, 3'd0, 3'd0);
        run_chk("after_rst", 0, 4, 1);

        // Mid-run start pulse ignored; start held through done relaunches after one idle cycle.
        start_v[0] = 1'b1;
        @(negedge clk);
        cyc = 0;
        while (busy_v[0] && cyc < LIMIT) begin
            cyc++;
            start_v[0] = (cyc == 5) || (cyc >= 14);
            @(negedge clk);
        end
        chk("held_len1", 32'(cyc), 32'd16);
        chk("held_done1", 32'(done_v[0]), 32'd1);
        @(negedge clk);
        chk("held_idle_busy", 32'(busy_v[0]), 32'd0);
        chk("held_idle_done", 32'(done_v[0]), 32'd0);
        @(negedge clk);
        chk("held_relaunch", 32'(busy_v[0]), 32'd1);
        start_v[0] = 1'b0;
        cyc = 0;
        while (busy_v[0] && cyc < LIMIT) begin
            cyc++;
            @(negedge clk);
        end
        chk("held_len2", 32'(cyc), 32'd16);
        chk("held_done2", 32'(done_v[0]), 32'd1);
        chk("held_pass2", 32'(pass_v[0]), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/nor_gate_checker.md
# nor_gate_checker

Self-checking stimulus sequencer wrapped around the two-input NOR-derived gate block. It drives all four `a`/`b` input combinations into the gate under test and holds each one for a programmable settle time. On the last cycle of each hold it samples the gate's derived AND, OR and NOT outputs, compares them against golden values and reports a pass/fail verdict and an error count. It sits directly upstream of the gate, as its driver, and directly downstream of it, as its consumer, for bring-up and regression.

## Interface
- `HOLD_CYCLES`, default 4: cycles each vector is held before sampling. Legal range 1..255.
- `SWEEPS`, default 1: number of full 4-vector sweeps per run. Legal range 1..255.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: level, sampled only in IDLE.
- `a` out 1: stimulus to the gate's `a` input.
- `b` out 1: stimulus to the gate's `b` input.
- `and_in` in 1: gate's derived AND output.
- `or_in` in 1: gate's derived OR output.
- `not_in` in 1: gate's derived NOT output, equal to ~a.
- `busy` out 1: high while vectors are applied.
- `done` out 1: one-cycle pulse when a run ends.
- `pass` out 1: run verdict.
- `err_cnt` out 8: count of failing vector samples.
- `ff_vec` out 2: first failing `{a,b}`. Present only under the macro.
- `ff_bits` out 3: first failing mismatch mask `{and,or,not}`. Present only under the macro.

## Operation
- Reset values: `a`=0, `b`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `ff_vec`=0, `ff_bits`=0, FSM in IDLE.
- States and transitions:
  - IDLE -> RUN when `start`=1. On acceptance: clear `err_cnt`, `pass`, `ff_*`; vector index=0, hold count=0, sweep count=0.
  - RUN -> DONE after the final sample of the final sweep.
  - DONE -> IDLE unconditionally after one cycle.
- Vector order is `{a,b}` = 00, 01, 10, 11, with `a` as MSB. The order restarts at 00 for each sweep.
- Expected outputs: and=a&b, or=a|b, not=~a.
- Mismatch mask = `{and_in^exp_and, or_in^exp_or, not_in^exp_not}`.
- A sample fails if the mask is nonzero. Each failing sample adds 1 to `err_cnt`.
- `err_cnt` saturates at 255 and never wraps.
- `pass` is written in the cycle `done` is high, as `err_cnt` final == 0. It then holds until the next accepted `start` or reset.
- `start` is ignored in RUN and DONE. A `start` held high through DONE is accepted on the first IDLE cycle.
- Reset mid-run: all outputs return to their reset values on the next edge and the run is abandoned. No `done` pulse is produced.

## Timing
- `start`=1 at edge N in IDLE -> `busy`=1 and `{a,b}`=00 from cycle N+1.
- Each vector is driven for exactly `HOLD_CYCLES` cycles. Sampling happens on the last of them, at hold count `HOLD_CYCLES`-1.
- With `HOLD_CYCLES`=1, sampling happens in the same cycle the vector is applied. Gate outputs must therefore be combinational.
- `busy` stays high for exactly 4·`HOLD_CYCLES`·`SWEEPS` cycles.
- `done` is high for one cycle, in the cycle immediately after `busy` falls.
- `err_cnt` and `pass` are final and valid in that same cycle.
- `{a,b}` returns to 00 when `busy` falls.
- `err_cnt` increments are registered: the count is visible one cycle after the failing sample.

## Configuration
- Macro: `NOR_CHK_FIRST_FAIL_EN`.
- Defined:
  - `ff_vec`/`ff_bits` ports exist.
  - On the first failing sample of a run, they capture the current `{a,b}` and the mismatch mask.
  - They are frozen until the next accepted `start` or reset.
  - If no sample fails they stay 0.
- Undefined: ports and capture logic are absent. All other behaviour is identical.

## Test plan
- Correct gate, `HOLD_CYCLES`=4, `SWEEPS`=1, `start` pulse -> `busy` high 16 cycles; `done` pulse on cycle 17; `pass`=1; `err_cnt`=0.
- `or_in` stuck at 0 -> `err_cnt`=3 (vectors 01, 10, 11); `pass`=0; with the macro defined, `ff_vec`=01 and `ff_bits`=010.
- `not_in` inverted, `SWEEPS`=2 -> `err_cnt`=8; `pass`=0; with the macro defined, `ff_vec`=00 and `ff_bits`=001.
- All outputs wrong, `HOLD_CYCLES`=1, `SWEEPS`=100 -> 400 failing samples; `err_cnt` saturates at 255; `busy` high 400 cycles.
- `rst_n`=0 for one cycle at cycle 6 of a run -> next cycle `busy`=0, `a`=`b`=0, `err_cnt`=0, no `done`; a new `start` runs a full sequence normally.
- `start` re-pulsed while `busy`, and `start` held high through `done` -> the mid-run pulse has no effect; the held `start` launches a new run whose first `busy` cycle follows one IDLE cycle.
